// File: rtl/game_event_scheduler.sv
// Event sequencer for main_game_logic: merges upstream user events with level-paced gravity
// ticks through round-robin arbitration into a single-entry output slot.
module game_event_scheduler #(
    parameter int unsigned EVENT_W     = 3,
    parameter int unsigned LEVEL_W     = 4,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned BASE_PERIOD = 25_000_000,
    parameter int unsigned PERIOD_STEP = 2_000_000,
    parameter int unsigned MIN_PERIOD  = 2_500_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [EVENT_W-1:0] user_event_i,
    input  logic               user_event_ready_i,
    output logic               user_event_rd_req_o,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               pause_i,
    input  logic               restart_i,
    output logic [EVENT_W-1:0] evt_o,
    output logic               evt_is_tick_o,
    output logic               evt_ready_o,
    input  logic               evt_rd_req_i,
    output logic [7:0]         missed_ticks_o
);

    localparam int unsigned PW = CNT_W + LEVEL_W;

    logic [PW-1:0]      step_prod;
    logic [PW-1:0]      period_full;
    logic [CNT_W-1:0]   reload_val;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_pending_q, tick_pending_d;
    logic               last_tick_q, last_tick_d;
    logic [7:0]         missed_q, missed_d;
    logic               evt_ready_q, evt_ready_d;
    logic               evt_is_tick_q, evt_is_tick_d;
    logic [EVENT_W-1:0] evt_q, evt_d;

    logic fire;
    logic slot_free;
    logic user_grant;
    logic tick_grant;

    // Subtraction is only taken when it cannot underflow.
    always_comb begin
        step_prod = PW'(level_i) * PW'(PERIOD_STEP);
        if (step_prod >= PW'(BASE_PERIOD)) begin
            period_full = PW'(MIN_PERIOD);
        end else if ((PW'(BASE_PERIOD) - step_prod) < PW'(MIN_PERIOD)) begin
            period_full = PW'(MIN_PERIOD);
        end else begin
            period_full = PW'(BASE_PERIOD) - step_prod;
        end
        reload_val = CNT_W'(period_full - PW'(1));
    end

    assign fire      = !pause_i && (cnt_q == '0);
    assign slot_free = !evt_ready_q || evt_rd_req_i;

    // On a tie the side that did not win last time is granted.
    always_comb begin
        user_grant = 1'b0;
        tick_grant = 1'b0;
        if (slot_free && !rst_i) begin
            if (user_event_ready_i && tick_pending_q) begin
                if (last_tick_q) begin
                    user_grant = 1'b1;
                end else begin
                    tick_grant = 1'b1;
                end
            end else if (user_event_ready_i) begin
                user_grant = 1'b1;
            end else if (tick_pending_q) begin
                tick_grant = 1'b1;
            end
        end
    end

    assign user_event_rd_req_o = user_grant;

    always_comb begin
        cnt_d          = cnt_q;
        tick_pending_d = tick_pending_q;
        missed_d       = missed_q;
        last_tick_d    = last_tick_q;
        evt_ready_d    = evt_ready_q;
        evt_is_tick_d  = evt_is_tick_q;
        evt_d          = evt_q;

        if (restart_i) begin
            cnt_d = reload_val;
        end else if (!pause_i) begin
            cnt_d = (cnt_q == '0) ? reload_val : cnt_q - CNT_W'(1);
        end

        if (restart_i) begin
            tick_pending_d = 1'b0;
            missed_d       = 8'd0;
        end else begin
            if (fire) begin
                tick_pending_d = 1'b1;
            end else if (tick_grant) begin
                tick_pending_d = 1'b0;
            end
            if (fire && tick_pending_q && !tick_grant && (missed_q != 8'hFF)) begin
                missed_d = missed_q + 8'd1;
            end
        end

        if (user_grant) begin
            evt_ready_d   = 1'b1;
            evt_is_tick_d = 1'b0;
            evt_d         = user_event_i;
            last_tick_d   = 1'b0;
        end else if (tick_grant) begin
            evt_ready_d   = 1'b1;
            evt_is_tick_d = 1'b1;
            evt_d         = '0;
            last_tick_d   = 1'b1;
        end else if (evt_rd_req_i && evt_ready_q) begin
            evt_ready_d   = 1'b0;
            evt_is_tick_d = 1'b0;
            evt_d         = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q          <= reload_val;
            tick_pending_q <= 1'b0;
            missed_q       <= 8'd0;
            last_tick_q    <= 1'b1;
            evt_ready_q    <= 1'b0;
            evt_is_tick_q  <= 1'b0;
            evt_q          <= '0;
        end else begin
            cnt_q          <= cnt_d;
            tick_pending_q <= tick_pending_d;
            missed_q       <= missed_d;
            last_tick_q    <= last_tick_d;
            evt_ready_q    <= evt_ready_d;
            evt_is_tick_q  <= evt_is_tick_d;
            evt_q          <= evt_d;
        end
    end

    assign evt_o          = evt_q;
    assign evt_is_tick_o  = evt_is_tick_q;
    assign evt_ready_o    = evt_ready_q;
    assign missed_ticks_o = missed_q;

endmodule

// File: tb/tb_game_event_scheduler.sv
// Directed self-checking bench for game_event_scheduler with a short tick period
// (base 10, step 2, floor 4); expected values are hand-derived cycle indices.
module tb_game_event_scheduler;

    logic       clk;
    logic       rst;
    logic [2:0] user_event;
    logic       user_ready;
    logic       user_rd_req;
    logic [3:0] level;
    logic       pause;
    logic       restart;
    logic [2:0] evt;
    logic       evt_is_tick;
    logic       evt_ready;
    logic       evt_rd_req;
    logic [7:0] missed;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    game_event_scheduler #(
        .EVENT_W     (3),
        .LEVEL_W     (4),
        .CNT_W       (25),
        .BASE_PERIOD (10),
        .PERIOD_STEP (2),
        .MIN_PERIOD  (4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .user_event_i        (user_event),
        .user_event_ready_i  (user_ready),
        .user_event_rd_req_o (user_rd_req),
        .level_i             (level),
        .pause_i             (pause),
        .restart_i           (restart),
        .evt_o               (evt),
        .evt_is_tick_o       (evt_is_tick),
        .evt_ready_o         (evt_ready),
        .evt_rd_req_i        (evt_rd_req),
        .missed_ticks_o      (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset release (k = 0).
    task automatic reset_dut(input logic [3:0] lvl);
        rst        = 1'b1;
        level      = lvl;
        user_ready = 1'b0;
        user_event = 3'd0;
        pause      = 1'b0;
        restart    = 1'b0;
        evt_rd_req = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // First tick visible at k = period+1, then every period cycles.
    task automatic run_level(input logic [3:0] lvl, input int period);
        logic exp_tick;
        reset_dut(lvl);
        for (int k = 1; k <= 3 * period + 1; k++) begin
            step();
            exp_tick = (k >= period + 1) && (((k - period - 1) % period) == 0);
            check($sformatf("lvl%0d_tick_k%0d", lvl, k), evt_is_tick, exp_tick);
            check($sformatf("lvl%0d_rdreq_k%0d", lvl, k), user_rd_req, 0);
        end
        check($sformatf("lvl%0d_missed", lvl), missed, 0);
    endtask

    initial begin
        logic exp_tick;

        // Reset values, with upstream offering an event during reset.
        rst        = 1'b1;
        level      = 4'd0;
        user_ready = 1'b1;
        user_event = 3'd5;
        pause      = 1'b0;
        restart    = 1'b0;
        evt_rd_req = 1'b1;
        step();
        step();
        check("rst_ready", evt_ready, 0);
        check("rst_tick", evt_is_tick, 0);
        check("rst_evt", evt, 0);
        check("rst_missed", missed, 0);
        check("rst_rdreq", user_rd_req, 0);

        // Tick periods: level 0 -> 10, 2 -> 6, 7 and 15 clamp to 4.
        run_level(4'd0, 10);
        run_level(4'd2, 6);
        run_level(4'd7, 4);
        run_level(4'd15, 4);

        // Continuous user events interleaved with ticks.
        reset_dut(4'd0);
        user_ready = 1'b1;
        user_event = 3'd5;
        #1;
        check("alt_rdreq_k0", user_rd_req, 1);
        for (int k = 1; k <= 22; k++) begin
            step();
            exp_tick = (k == 11) || (k == 21);
            check($sformatf("alt_rdreq_k%0d", k), user_rd_req, (k != 10) && (k != 20));
            check($sformatf("alt_ready_k%0d", k), evt_ready, 1);
            check($sformatf("alt_tick_k%0d", k), evt_is_tick, exp_tick);
            check($sformatf("alt_evt_k%0d", k), evt, exp_tick ? 0 : 5);
        end

        // Downstream stall: first tick held, later fires counted as misses.
        reset_dut(4'd0);
        evt_rd_req = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            step();
            check($sformatf("stall_rdreq_k%0d", k), user_rd_req, 0);
            if (k == 11 || k == 45) begin
                check($sformatf("stall_ready_k%0d", k), evt_ready, 1);
                check($sformatf("stall_tick_k%0d", k), evt_is_tick, 1);
                check($sformatf("stall_evt_k%0d", k), evt, 0);
            end
            if (k == 29) check("stall_missed_k29", missed, 0);
            if (k == 30) check("stall_missed_k30", missed, 1);
            if (k == 45) check("stall_missed_k45", missed, 2);
            if (k == 11) begin
                user_ready = 1'b1;
                user_event = 3'd5;
            end
        end

        // Restart while a tick is pending and misses are recorded.
        restart    = 1'b1;
        evt_rd_req = 1'b1;
        #1;
        check("rs_rdreq", user_rd_req, 1);
        step();
        restart    = 1'b0;
        user_ready = 1'b0;
        check("rs_missed", missed, 0);
        check("rs_ready", evt_ready, 1);
        check("rs_tick", evt_is_tick, 0);
        check("rs_evt", evt, 5);
        for (int r = 2; r <= 13; r++) begin
            step();
            check($sformatf("rs_tick_r%0d", r), evt_is_tick, r == 12);
            if (r == 2) check("rs_ready_r2", evt_ready, 0);
        end

        // Pause for 20 cycles with the counter at 5.
        reset_dut(4'd0);
        for (int k = 1; k <= 32; k++) begin
            step();
            check($sformatf("pause_tick_k%0d", k), evt_is_tick, k == 31);
            if (k == 4) pause = 1'b1;
            if (k == 24) pause = 1'b0;
        end

        // Reset during an active user handshake.
        reset_dut(4'd0);
        user_ready = 1'b1;
        user_event = 3'd3;
        step();
        check("mid_evt", evt, 3);
        check("mid_ready", evt_ready, 1);
        rst = 1'b1;
        #1;
        check("mid_rdreq_in_rst", user_rd_req, 0);
        step();
        check("mid_ready_after_rst", evt_ready, 0);
        rst = 1'b0;

        // Missed-tick counter saturates.
        reset_dut(4'd7);
        evt_rd_req = 1'b0;
        repeat (1200) step();
        check("sat_missed", missed, 255);
        check("sat_tick", evt_is_tick, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
